// File: rtl/mvdm_rx_pkg.sv
// Shared types and sizes for the MVDM result-port receiver.
// Frame = two records of {mv_idx, sad}, sent MSB-first.
package mvdm_rx_pkg;

    localparam int FRAME_BITS = 56;
    localparam int REC_BITS   = 28;
    localparam int IDX_W      = 4;
    localparam int SAD_W      = 24;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [SAD_W-1:0] sad;
    } rec_t;

endpackage

// File: rtl/sad_frame_hold.sv
// Holding register for a completed frame with pending/ack and overrun flag.
// Ports: load/load_data from the shifter, ack from consumer; pending, data, overrun out.
module sad_frame_hold #(
    parameter int W = 56
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ack,
    output logic         pending,
    output logic [W-1:0] data,
    output logic         overrun
);

    logic         pending_q, pending_d;
    logic [W-1:0] data_q, data_d;
    logic         overrun_q, overrun_d;

    always_comb begin
        pending_d = pending_q;
        data_d    = data_q;
        overrun_d = overrun_q;
        if (ack && pending_q) begin
            pending_d = 1'b0;
        end
        if (load) begin
            pending_d = 1'b1;
            data_d    = load_data;
            // An ack in the same cycle consumes the old frame, so no loss.
            if (pending_q && !ack) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    assign pending = pending_q;
    assign data    = data_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/sad_stream_deserializer.sv
// Reassembles MSB-first serial result frames and splits them into two records.
// Ports: ser_valid/ser_bit in, frame_ack in; frame_pending/frame_data/idx/sad, err flags, frame_cnt out.
module sad_stream_deserializer
    import mvdm_rx_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ser_valid,
    input  logic                  ser_bit,
    input  logic                  frame_ack,
    output logic                  frame_pending,
    output logic [FRAME_BITS-1:0] frame_data,
    output logic [IDX_W-1:0]      idx0,
    output logic [SAD_W-1:0]      sad0,
    output logic [IDX_W-1:0]      idx1,
    output logic [SAD_W-1:0]      sad1,
    output logic                  err_short,
    output logic                  err_overrun,
    output logic [15:0]           frame_cnt
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BITS - 1);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    // Only FRAME_BITS-1 bits are stored; the final bit comes straight from ser_bit.
    logic [FRAME_BITS-2:0] shreg_q, shreg_d;
    logic                  err_short_q, err_short_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  done;
    logic [FRAME_BITS-1:0] new_frame;
    rec_t                  rec0, rec1;

    assign new_frame = {shreg_q, ser_bit};

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        err_short_d = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ser_valid) begin
                    shreg_d   = {{(FRAME_BITS-2){1'b0}}, ser_bit};
                    bit_cnt_d = CNT_W'(1);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (ser_valid) begin
                    if (bit_cnt_q == LAST) begin
                        done      = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        shreg_d   = {shreg_q[FRAME_BITS-3:0], ser_bit};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else begin
                    err_short_d = 1'b1;
                    bit_cnt_d   = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        frame_cnt_d = frame_cnt_q + {15'd0, done};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            err_short_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            err_short_q <= err_short_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    sad_frame_hold #(
        .W (FRAME_BITS)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (done),
        .load_data (new_frame),
        .ack       (frame_ack),
        .pending   (frame_pending),
        .data      (frame_data),
        .overrun   (err_overrun)
    );

    assign rec0      = frame_data[FRAME_BITS-1:REC_BITS];
    assign rec1      = frame_data[REC_BITS-1:0];
    assign idx0      = rec0.idx;
    assign sad0      = rec0.sad;
    assign idx1      = rec1.idx;
    assign sad1      = rec1.sad;
    assign err_short = err_short_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sad_stream_deserializer.sv
// Directed bench for sad_stream_deserializer.
// Drives on falling edges, samples just before the next drive.
module tb_sad_stream_deserializer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ser_valid = 1'b0;
    logic        ser_bit = 1'b0;
    logic        frame_ack = 1'b0;
    logic        frame_pending;
    logic [55:0] frame_data;
    logic [3:0]  idx0, idx1;
    logic [23:0] sad0, sad1;
    logic        err_short, err_overrun;
    logic [15:0] frame_cnt;

    int checks = 0;
    int passed = 0;

    localparam logic [55:0] FA = 56'hA123456500ABCD;
    localparam logic [55:0] FB = 56'h3FEDCBAC012345;

    always #5 clk = ~clk;

    sad_stream_deserializer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ser_valid     (ser_valid),
        .ser_bit       (ser_bit),
        .frame_ack     (frame_ack),
        .frame_pending (frame_pending),
        .frame_data    (frame_data),
        .idx0          (idx0),
        .sad0          (sad0),
        .idx1          (idx1),
        .sad1          (sad1),
        .err_short     (err_short),
        .err_overrun   (err_overrun),
        .frame_cnt     (frame_cnt)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ser_valid = 1'b0;
        frame_ack = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk);
        ser_valid = 1'b1;
        ser_bit = b;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        ser_valid = 1'b0;
        ser_bit = 1'b1;
        frame_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({frame_pending, frame_data, err_short, err_overrun, frame_cnt} !== '0)
            $display("FAIL reset_outputs got pend=%b data=%h es=%b eo=%b cnt=%0d want all 0",
                     frame_pending, frame_data, err_short, err_overrun, frame_cnt);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        for (int i = 55; i >= 0; i--) drive_bit(FA[i]);
        idle_cycle();
        checks++;
        if ({frame_pending, idx0, sad0, idx1, sad1, frame_cnt} !==
            {1'b1, 4'hA, 24'h123456, 4'h5, 24'h00ABCD, 16'd1})
            $display("FAIL single_decode got p=%b %h %h %h %h cnt=%0d want 1 a 123456 5 00abcd 1",
                     frame_pending, idx0, sad0, idx1, sad1, frame_cnt);
        else passed++;
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        checks++;
        if ({frame_pending, frame_data} !== {1'b0, FA})
            $display("FAIL single_ack got p=%b d=%h want 0 %h", frame_pending, frame_data, FA);
        else passed++;
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        checks++;
        if ({frame_pending, err_overrun, frame_cnt} !== {1'b0, 1'b0, 16'd1})
            $display("FAIL stray_ack got p=%b eo=%b cnt=%0d want 0 0 1",
                     frame_pending, err_overrun, frame_cnt);
        else passed++;
    endtask

    task automatic test_short();
        do_reset();
        for (int i = 55; i >= 36; i--) drive_bit(FB[i]);
        idle_cycle();
        checks++;
        if (err_short !== 1'b0)
            $display("FAIL short_early got %b want 0", err_short);
        else passed++;
        idle_cycle();
        checks++;
        if (err_short !== 1'b1)
            $display("FAIL short_pulse got %b want 1", err_short);
        else passed++;
        idle_cycle();
        checks++;
        if ({err_short, frame_pending, frame_cnt} !== {1'b0, 1'b0, 16'd0})
            $display("FAIL short_after got es=%b p=%b cnt=%0d want 0 0 0",
                     err_short, frame_pending, frame_cnt);
        else passed++;
        for (int i = 55; i >= 0; i--) drive_bit(FB[i]);
        idle_cycle();
        checks++;
        if ({frame_pending, idx0, sad0, idx1, sad1, frame_cnt} !==
            {1'b1, 4'h3, 24'hFEDCBA, 4'hC, 24'h012345, 16'd1})
            $display("FAIL short_then_full got p=%b %h %h %h %h cnt=%0d want 1 3 fedcba c 012345 1",
                     frame_pending, idx0, sad0, idx1, sad1, frame_cnt);
        else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 112; i++) begin
            drive_bit(i < 56 ? FA[55-i] : FB[111-i]);
            frame_ack = 1'b0;
            if (i == 56) begin
                checks++;
                if ({frame_pending, frame_data, frame_cnt} !== {1'b1, FA, 16'd1})
                    $display("FAIL b2b_first got p=%b d=%h cnt=%0d want 1 %h 1",
                             frame_pending, frame_data, frame_cnt, FA);
                else passed++;
                frame_ack = 1'b1;
            end
            if (i == 58) begin
                checks++;
                if (frame_pending !== 1'b0)
                    $display("FAIL b2b_acked got %b want 0", frame_pending);
                else passed++;
            end
        end
        idle_cycle();
        checks++;
        if ({frame_pending, frame_data, frame_cnt, err_overrun} !== {1'b1, FB, 16'd2, 1'b0})
            $display("FAIL b2b_second got p=%b d=%h cnt=%0d eo=%b want 1 %h 2 0",
                     frame_pending, frame_data, frame_cnt, err_overrun, FB);
        else passed++;
    endtask

    task automatic test_overrun();
        do_reset();
        for (int i = 0; i < 112; i++) drive_bit(i < 56 ? FA[55-i] : FB[111-i]);
        idle_cycle();
        checks++;
        if ({err_overrun, frame_pending, frame_data, frame_cnt} !== {1'b1, 1'b1, FB, 16'd2})
            $display("FAIL overrun got eo=%b p=%b d=%h cnt=%0d want 1 1 %h 2",
                     err_overrun, frame_pending, frame_data, frame_cnt, FB);
        else passed++;
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({err_overrun, frame_pending} !== 2'b10)
            $display("FAIL overrun_sticky got eo=%b p=%b want 1 0", err_overrun, frame_pending);
        else passed++;
    endtask

    task automatic test_ack_coincident();
        do_reset();
        for (int i = 0; i < 112; i++) begin
            drive_bit(i < 56 ? FA[55-i] : FB[111-i]);
            if (i == 111) frame_ack = 1'b1;
        end
        idle_cycle();
        checks++;
        if ({frame_pending, frame_data, err_overrun, frame_cnt} !== {1'b1, FB, 1'b0, 16'd2})
            $display("FAIL ack_coincident got p=%b d=%h eo=%b cnt=%0d want 1 %h 0 2",
                     frame_pending, frame_data, err_overrun, frame_cnt, FB);
        else passed++;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 55; i >= 0; i--) drive_bit(FB[i]);
        for (int i = 55; i >= 26; i--) drive_bit(FA[i]);
        checks++;
        if ({frame_pending, frame_cnt} !== {1'b1, 16'd1})
            $display("FAIL pre_reset got p=%b cnt=%0d want 1 1", frame_pending, frame_cnt);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({frame_pending, frame_data, err_short, err_overrun, frame_cnt} !== '0)
            $display("FAIL async_reset got p=%b d=%h es=%b eo=%b cnt=%0d want all 0",
                     frame_pending, frame_data, err_short, err_overrun, frame_cnt);
        else passed++;
        @(negedge clk);
        ser_valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 55; i >= 0; i--) drive_bit(FA[i]);
        idle_cycle();
        checks++;
        if ({frame_pending, frame_data, frame_cnt, err_short} !== {1'b1, FA, 16'd1, 1'b0})
            $display("FAIL post_reset got p=%b d=%h cnt=%0d es=%b want 1 %h 1 0",
                     frame_pending, frame_data, frame_cnt, err_short, FA);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_short();
        test_back_to_back();
        test_overrun();
        test_ack_coincident();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sad_stream_deserializer.md
Name: sad_stream_deserializer

Overview:
- Receive-side counterpart of the MVDM core's serial result port; used in the chip-level testbench and FPGA bring-up harness.
- Samples the 1-bit out_sad stream qualified by out_valid and reassembles each FRAME_BITS-bit result frame.
- Splits each frame into two {mv_idx, sad} records and presents them on a hold-until-ack interface.
- Flags short frames and overruns.

Parameters:
- FRAME_BITS, 56, bits per result frame; equals 2*REC_BITS
- REC_BITS, 28, bits per record = IDX_W + SAD_W
- IDX_W, 4, motion-vector index width (record MSBs)
- SAD_W, 24, SAD value width (record LSBs)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ser_valid  in  1  frame qualifier (connects to chip out_valid)
- ser_bit  in  1  serial data, MSB of frame first (connects to chip out_sad)
- frame_ack  in  1  consumer has taken the held frame
- frame_pending  out  1  held frame is valid and unacknowledged
- frame_data  out  FRAME_BITS  last complete frame, bit FRAME_BITS-1 = first received bit
- idx0  out  IDX_W  frame_data[55:52]
- sad0  out  SAD_W  frame_data[51:28]
- idx1  out  IDX_W  frame_data[27:24]
- sad1  out  SAD_W  frame_data[23:0]
- err_short  out  1  one-cycle pulse: ser_valid dropped mid-frame
- err_overrun  out  1  sticky: a frame completed while the previous one was still pending
- frame_cnt  out  16  count of completed frames, wraps at 2^16

Behaviour:
- Reset (async assert, sync deassert by the upstream reset tree):
  - all outputs 0; shift register 0; bit counter 0; state IDLE.
- Reset mid-frame discards partial data. No flag is raised.
- State IDLE:
  - On ser_valid=1, shift in ser_bit, set bit_cnt=1, go to SHIFT.
  - If FRAME_BITS==1 the frame completes this cycle (degenerate case; not used).
- State SHIFT:
  - ser_valid=1: shift left, inserting ser_bit at the LSB; bit_cnt++.
  - When the bit shifted in is number FRAME_BITS (bit_cnt==FRAME_BITS-1 before the increment), the frame completes:
    - next-cycle frame_data = {shreg[FRAME_BITS-2:0], ser_bit};
    - frame_pending=1; frame_cnt++; bit_cnt=0; return to IDLE.
  - ser_valid=0 before completion: err_short=1 for exactly the next cycle; discard the partial frame; bit_cnt=0; go to IDLE. frame_data and frame_pending are unchanged.
- Back-to-back frames:
  - ser_valid held high across the boundary starts a new frame on the next cycle with no gap required.
  - Bit FRAME_BITS+1 is bit 1 of the next frame.
- Latency:
  - frame_pending rises on the clock edge that samples the last bit; visible the cycle after the last bit.
  - idx/sad outputs are combinational slices of frame_data.
- Ack rules:
  - frame_ack=1 while frame_pending=1 clears frame_pending at the next edge. frame_data holds its value.
  - frame_ack while not pending is ignored.
- Overrun:
  - Completion while frame_pending=1 and frame_ack=0: frame_data is overwritten with the new frame, frame_pending stays 1, err_overrun is set.
  - err_overrun clears only on reset.
- Completion and frame_ack in the same cycle: the ack consumes the old frame, the new frame loads, frame_pending stays 1, no overrun.
- ser_bit is ignored whenever ser_valid=0.

Decomposition:
- Package mvdm_rx_pkg holds:
  - FRAME_BITS, REC_BITS, IDX_W, SAD_W;
  - state enum {IDLE, SHIFT};
  - a record struct {idx, sad}.
- Optional sub-module sad_frame_hold: pending/ack/overrun register stage, instantiated once.
- Shifter and FSM remain in the top module.

Test Plan:
- Single frame: send 56 bits of 0xA_123456_5_00ABCD MSB-first under ser_valid -> one cycle later frame_pending=1, idx0=0xA, sad0=0x123456, idx1=0x5, sad1=0x00ABCD, frame_cnt=1.
- Short frame: ser_valid high for 20 bits, then low -> err_short pulses exactly 1 cycle; frame_pending stays 0; frame_cnt=0. A following full frame decodes correctly.
- Back-to-back: 112 bits continuous, first frame acked on arrival -> two completions 56 cycles apart, frame_cnt=2, err_overrun=0, second frame values correct.
- Overrun: two back-to-back frames with no ack -> err_overrun=1, frame_data equals the second frame, frame_pending=1.
- Ack coincident with completion: assert frame_ack on the exact cycle frame 2's last bit is sampled -> frame_pending remains 1 with frame 2 data, err_overrun=0.
- Async reset at bit 30 of a frame: assert rst_n=0 between edges -> all outputs 0 immediately. After release, a full frame decodes correctly with frame_cnt=1.
